// File: rtl/array_6_pkg.sv
// Shared geometry and FSM encoding for the array_6 requester-side controller.
package array_6_pkg;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned WIDTH  = 22;
    localparam int unsigned GRAN   = 11;
    localparam int unsigned MASK_W = WIDTH / GRAN;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/array_6_resp_fifo.sv
// Two-entry read-response FIFO; push and pop may coincide, head shows the oldest entry.
module array_6_resp_fifo
    import array_6_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop & (count != 2'd0);
        do_push = push & ((count != 2'd2) | do_pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign valid = (count != 2'd0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/array_6_port_ctrl.sv
// Zero-fills the 16x22 masked array after reset, then arbitrates write/read
// requests onto its single RW0 port with credit-limited read responses.
module array_6_port_ctrl
    import array_6_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [MASK_W-1:0] wr_mask,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WIDTH-1:0]  resp_data,
    output logic              init_done,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [MASK_W-1:0] RW0_wmask,
    output logic [WIDTH-1:0]  RW0_wdata,
    input  logic [WIDTH-1:0]  RW0_rdata
);

    state_t            state;
    logic [ADDR_W-1:0] sweep;
    logic              last_was_read;
    logic              inflight;
    logic [1:0]        fifo_count;
    logic              pop;
    logic [2:0]        occupancy;
    logic              rd_elig;
    logic              run;
    logic              wr_go;
    logic              rd_go;
    logic              wr_live;

    // Occupancy counts the read already issued to the array, so the FIFO can never overflow.
    always_comb begin
        pop       = resp_valid & resp_ready;
        occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
        rd_elig   = (occupancy < 3'd2);
        run       = (state == RUN);
        wr_ready  = run & ~(rd_valid & rd_elig & ~last_was_read);
        rd_ready  = run & rd_elig & ~(wr_valid & last_was_read);
        wr_go     = wr_valid & wr_ready;
        rd_go     = rd_valid & rd_ready;
        wr_live   = wr_go & (wr_mask != '0);
    end

    always_comb begin
        RW0_addr  = '0;
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_wmask = '0;
        RW0_wdata = '0;
        if (reset_n) begin
            if (state == INIT) begin
                RW0_addr  = sweep;
                RW0_en    = 1'b1;
                RW0_wmode = 1'b1;
                RW0_wmask = '1;
            end else if (wr_live) begin
                RW0_addr  = wr_addr;
                RW0_en    = 1'b1;
                RW0_wmode = 1'b1;
                RW0_wmask = wr_mask;
                RW0_wdata = wr_data;
            end else if (rd_go) begin
                RW0_addr  = rd_addr;
                RW0_en    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= INIT;
            sweep         <= '0;
            init_done     <= 1'b0;
            last_was_read <= 1'b0;
            inflight      <= 1'b0;
        end else begin
            inflight <= rd_go;
            case (state)
                INIT: begin
                    sweep <= sweep + 1'b1;
                    if (sweep == ADDR_W'(DEPTH - 1)) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    // A zero-mask write never reaches the array, so it does not claim a turn.
                    if (rd_go) begin
                        last_was_read <= 1'b1;
                    end else if (wr_live) begin
                        last_was_read <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    array_6_resp_fifo u_resp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data (RW0_rdata),
        .pop       (pop),
        .valid     (resp_valid),
        .head      (resp_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_array_6_port_ctrl.sv
// Self-checking bench for array_6_port_ctrl with a behavioural array and a response scoreboard.
module tb_array_6_port_ctrl;
    import array_6_pkg::*;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              wr_valid, wr_ready, rd_valid, rd_ready;
    logic [ADDR_W-1:0] wr_addr, rd_addr, RW0_addr;
    logic [MASK_W-1:0] wr_mask, RW0_wmask;
    logic [WIDTH-1:0]  wr_data, resp_data, RW0_wdata, RW0_rdata;
    logic              resp_valid, resp_ready, init_done, RW0_en, RW0_wmode;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] arr [DEPTH];
    logic [WIDTH-1:0] ref_mem [DEPTH];
    logic [WIDTH-1:0] sb [$];

    typedef struct packed {
        logic              wv;
        logic              rv;
        logic [ADDR_W-1:0] wa;
        logic [ADDR_W-1:0] ra;
        logic [MASK_W-1:0] wm;
        logic [WIDTH-1:0]  wd;
        logic              ewr;
        logic              erd;
        logic              een;
        logic              ewm;
    } vec_t;
    vec_t tbl [8];

    always #5 clock = ~clock;

    array_6_port_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_mask(wr_mask), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .init_done(init_done),
        .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
        .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
    );

    // Behavioural single-port masked array, read data registered one cycle.
    always @(posedge clock) begin
        if (RW0_en) begin
            if (RW0_wmode) begin
                for (int g = 0; g < MASK_W; g++)
                    if (RW0_wmask[g]) arr[RW0_addr][g*GRAN +: GRAN] = RW0_wdata[g*GRAN +: GRAN];
            end else begin
                RW0_rdata <= arr[RW0_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake not seen within bound at %0t", name, $time);
    endtask

    // Scoreboard: reference memory tracks accepted writes, reads push expected data.
    always @(negedge clock) begin
        if (reset_n) begin
            if (wr_valid && wr_ready) begin
                for (int g = 0; g < MASK_W; g++)
                    if (wr_mask[g]) ref_mem[wr_addr][g*GRAN +: GRAN] = wr_data[g*GRAN +: GRAN];
            end
            if (rd_valid && rd_ready) sb.push_back(ref_mem[rd_addr]);
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 32'(resp_valid), 32'd0);
                end else begin
                    chk("resp_data", 32'(resp_data), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic idle(input int n);
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [MASK_W-1:0] m,
                            input logic [WIDTH-1:0] d);
        int n = 0;
        wr_valid = 1'b1; wr_addr = a; wr_mask = m; wr_data = d;
        @(negedge clock);
        while (!wr_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!wr_ready) timeout("write_accept");
        @(posedge clock);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        int n = 0;
        rd_valid = 1'b1; rd_addr = a;
        @(negedge clock);
        while (!rd_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!rd_ready) timeout("read_accept");
        @(posedge clock);
        #1;
        rd_valid = 1'b0;
    endtask

    task automatic sweep_check();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            chk("sweep_ctrl", 32'({RW0_en, RW0_wmode, RW0_wmask, RW0_wdata}),
                32'({1'b1, 1'b1, {MASK_W{1'b1}}, {WIDTH{1'b0}}}));
            chk("sweep_addr", 32'(RW0_addr), 32'(i));
            chk("sweep_ready", 32'({wr_ready, rd_ready, init_done}), 32'd0);
        end
        @(negedge clock);
        chk("init_done", 32'(init_done), 32'd1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [ADDR_W-1:0] bp_addr [4];
        int k;
        int n;

        for (int i = 0; i < DEPTH; i++) begin
            arr[i]     = WIDTH'($urandom);
            ref_mem[i] = '0;
        end
        wr_valid = 1'b0; rd_valid = 1'b0; resp_ready = 1'b1;
        wr_addr = '0; rd_addr = '0; wr_mask = '0; wr_data = '0;

        tbl[0] = '{1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 22'h0,      1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 4'd2, 4'd0, 2'b11, 22'h2AAAA,  1'b1, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 4'd4, 4'd2, 2'b11, 22'h15555,  1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 4'd4, 4'd2, 2'b11, 22'h15555,  1'b1, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 4'd6, 4'd0, 2'b00, 22'h3FFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 4'd6, 4'd4, 2'b01, 22'h01234,  1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 4'd6, 4'd6, 2'b01, 22'h01234,  1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 4'd6, 4'd0, 2'b01, 22'h00ABC,  1'b1, 1'b0, 1'b1, 1'b1};

        // Reset values
        #2;
        chk("rst_ready", 32'({wr_ready, rd_ready}), 32'd0);
        chk("rst_resp", 32'({resp_valid, resp_data}), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_rw0", 32'({RW0_en, RW0_wmode, RW0_wmask, RW0_addr}), 32'd0);
        chk("rst_wdata", 32'(RW0_wdata), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        sweep_check();

        do_read(4'd5);
        idle(4);

        // Masked write, then read latency and merged data
        do_write(4'd3, 2'b11, 22'h3FFFFF);
        do_write(4'd3, 2'b10, 22'h0);
        do_read(4'd3);
        @(negedge clock);
        chk("mask_lat_t1", 32'(resp_valid), 32'd0);
        @(negedge clock);
        chk("mask_lat_t2", 32'(resp_valid), 32'd1);
        chk("mask_data", 32'(resp_data), 32'h0007FF);
        @(posedge clock);
        #1;
        idle(3);
        do_write(4'd0, 2'b11, 22'h00F0F);

        // Arbitration table
        for (int i = 0; i < 8; i++) begin
            wr_valid = tbl[i].wv; rd_valid = tbl[i].rv;
            wr_addr = tbl[i].wa; rd_addr = tbl[i].ra;
            wr_mask = tbl[i].wm; wr_data = tbl[i].wd;
            @(negedge clock);
            chk($sformatf("tbl%0d_ready", i), 32'({wr_ready, rd_ready}), 32'({tbl[i].ewr, tbl[i].erd}));
            chk($sformatf("tbl%0d_port", i), 32'({RW0_en, RW0_wmode}), 32'({tbl[i].een, tbl[i].ewm}));
            @(posedge clock);
            #1;
        end
        idle(4);

        // Contention: both channels valid for six cycles
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1; rd_valid = 1'b1;
            wr_addr = 4'(8 + i); wr_mask = 2'b11; wr_data = WIDTH'(32'h100 * (i + 1));
            rd_addr = 4'(i);
            @(negedge clock);
            chk($sformatf("cont%0d_ready", i), 32'({wr_ready, rd_ready}),
                32'({1'(i % 2), 1'(1 - i % 2)}));
            chk($sformatf("cont%0d_port", i), 32'({RW0_en, RW0_wmode}), 32'({1'b1, 1'(i % 2)}));
            @(posedge clock);
            #1;
        end
        idle(5);

        // Backpressure: four reads offered, consumer stalled
        bp_addr[0] = 4'd8; bp_addr[1] = 4'd9; bp_addr[2] = 4'd10; bp_addr[3] = 4'd2;
        resp_ready = 1'b0;
        k = 0;
        rd_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rd_addr = bp_addr[k];
            @(negedge clock);
            if (rd_ready) k++;
            @(posedge clock);
            #1;
        end
        chk("bp_accepted", 32'(k), 32'd2);
        rd_addr = bp_addr[k];
        @(negedge clock);
        chk("bp_stall_ready", 32'(rd_ready), 32'd0);
        @(posedge clock);
        #1;
        resp_ready = 1'b1;
        n = 0;
        while (k < 4 && n < 20) begin
            rd_addr = bp_addr[k];
            @(negedge clock);
            if (rd_ready) k++;
            @(posedge clock);
            #1;
            n++;
        end
        chk("bp_all_accepted", 32'(k), 32'd4);
        idle(6);
        chk("bp_drained", 32'(sb.size()), 32'd0);

        // Write then read same address on consecutive cycles
        do_write(4'd9, 2'b11, 22'h12345);
        do_read(4'd9);
        @(negedge clock);
        @(negedge clock);
        chk("wtr_valid", 32'(resp_valid), 32'd1);
        chk("wtr_data", 32'(resp_data), 32'h12345);
        @(posedge clock);
        #1;
        idle(3);

        // Reset with one response queued and one read in flight
        resp_ready = 1'b0;
        rd_valid = 1'b1; rd_addr = 4'd1;
        @(negedge clock);
        chk("mid_rd_a", 32'(rd_ready), 32'd1);
        @(posedge clock);
        #1;
        rd_addr = 4'd2;
        @(negedge clock);
        chk("mid_rd_b", 32'(rd_ready), 32'd1);
        @(posedge clock);
        #1;
        rd_valid = 1'b0;
        chk("mid_fifo_one", 32'(resp_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_resp", 32'({resp_valid, resp_data}), 32'd0);
        chk("mid_rst_port", 32'({RW0_en, init_done, wr_ready, rd_ready}), 32'd0);
        sb.delete();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        resp_ready = 1'b1;
        sweep_check();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("mid_no_stale", 32'(resp_valid), 32'd0);
        end
        @(posedge clock);
        #1;
        do_read(4'd9);
        idle(4);
        chk("final_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/array_6_port_ctrl.md
# array_6_port_ctrl

Requester-side controller for the 16x22 single-port masked array (`array_6_ext`, 11-bit mask granules). It zero-initialises the array after reset, then arbitrates independent write and read request channels onto the single RW0 port. Read data returns through a 2-entry response FIFO with valid/ready backpressure. It sits between the consuming pipeline and the array instance; the parent ties the array's `RW0_clk` to `clock`.

## Interface
- `DEPTH`, 16: array entries.
- `ADDR_W`, 4: log2(DEPTH).
- `WIDTH`, 22: data width.
- `GRAN`, 11: mask granule width.
- `MASK_W`, 2: WIDTH/GRAN.

Ports:
- `clock`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  write request present.
- `wr_ready`  out  1  write accepted this cycle when both are high.
- `wr_addr`  in  ADDR_W  write address.
- `wr_mask`  in  MASK_W  per-granule write enables.
- `wr_data`  in  WIDTH  write data.
- `rd_valid`  in  1  read request present.
- `rd_ready`  out  1  read accepted this cycle when both are high.
- `rd_addr`  in  ADDR_W  read address.
- `resp_valid`  out  1  response FIFO head valid.
- `resp_ready`  in  1  consumer pops the head.
- `resp_data`  out  WIDTH  read data, in request order.
- `init_done`  out  1  high once the zero-fill sweep is complete.
- `RW0_addr`  out  ADDR_W  array address.
- `RW0_en`  out  1  array enable.
- `RW0_wmode`  out  1  1 = write, 0 = read.
- `RW0_wmask`  out  MASK_W  array write mask.
- `RW0_wdata`  out  WIDTH  array write data.
- `RW0_rdata`  in  WIDTH  array read data, valid the cycle after a read enable.

## Operation
- **FSM states:** INIT, RUN.
  - Reset enters INIT with the sweep counter at 0.
  - Each INIT cycle: `RW0_en`=1, `wmode`=1, `wmask`=all-ones, `wdata`=0, `addr`=counter; the counter then increments.
  - After address DEPTH-1 is written: move to RUN and set `init_done`=1. `init_done` stays high until the next reset.
- **In INIT:** `wr_ready` and `rd_ready` are 0.
- **Read eligibility:** `rd_elig` = (fifo_count + inflight − pop) < 2.
  - pop = `resp_valid` & `resp_ready`.
  - inflight = a read was issued last cycle.
- **Arbitration in RUN:** at most one array operation per cycle.
  - If only one channel is valid and eligible, it is granted.
  - If both are, round-robin using a `last_was_read` flag, which is 0 after reset, so read wins first.
  - `wr_ready` = RUN & !(rd_valid & rd_elig & read_has_priority).
  - `rd_ready` = RUN & rd_elig & !(wr_valid & write_has_priority).
  - A ready never depends on its own channel's valid.
- **Port drive:** array outputs are driven combinationally from the granted request in the same cycle.
  - Write: `RW0_en`=1, `wmode`=1, `wmask`/`wdata`/`addr` from the request.
  - Read: `RW0_en`=1, `wmode`=0, `wmask`=0, `wdata`=0.
  - Write with `wr_mask`=0: accepted, but `RW0_en` stays 0 and the arbitration flag is unchanged.
  - No operation: every RW0 output is 0.
- **Response path:** the cycle after a read is issued, `RW0_rdata` is pushed into the FIFO.
  - Eligibility guarantees the FIFO never overflows.
  - Push and pop in the same cycle are legal.
  - Responses come out strictly in request order.
- **Ordering:** a write at cycle t followed by a read of the same address at t+1 returns the new data. No bypass logic is needed.
- **Reset mid-operation:** `reset_n` low immediately clears the FSM, counter, FIFO, inflight flag and arbitration flag. An in-flight read is discarded and the sweep restarts.

## Timing
- **Reset values:** `wr_ready`=0, `rd_ready`=0, `resp_valid`=0, `resp_data`=0, `init_done`=0. While `reset_n` is asserted, all RW0 outputs are 0.
- **Init:** exactly DEPTH cycles after reset release. `init_done` rises in cycle DEPTH+1 (counting from the first post-reset edge).
- **Read latency:** read handshake at t, array sampled at edge t, FIFO push at edge t+1, `resp_valid` at t+2.
- **Throughput:** with `resp_ready` held high, one read per cycle.
- **Backpressure:** with `resp_ready` held low, at most 2 reads are accepted; `rd_ready` stays 0 until a pop.
- **Writes:** take effect at the edge of the handshake cycle.

## Structure
- **Shared package `array_6_pkg`:** DEPTH, ADDR_W, WIDTH, GRAN, MASK_W; state enum {INIT, RUN}.
- **Sub-module `array_6_resp_fifo`:** 2-entry, WIDTH-wide, push/pop/count. Separating it keeps the credit logic local to the controller.

## Test plan
- **Reset sweep:** release reset → 16 consecutive writes to addresses 0..15 with data 0 and mask 2'b11; `init_done` high at cycle 17; a subsequent read of address 5 returns 0.
- **Masked write:** write address 3, data 22'h3FFFFF, mask 2'b11; then write address 3, data 0, mask 2'b10; read address 3 → `resp_data`=22'h0007FF at t+2.
- **Contention:** `wr_valid` and `rd_valid` held high for 6 cycles → grants alternate R, W, R, W, R, W; no cycle has two operations.
- **Backpressure:** `resp_ready`=0 with 4 reads offered → exactly 2 accepted; raise `resp_ready` → the remaining reads are accepted one per pop, responses arrive in order, no loss.
- **Write-then-read:** write address 9, data 22'h12345 at t; read address 9 at t+1 → 22'h12345.
- **Reset mid-operation:** assert `reset_n` low with one read in flight and FIFO count 1 → `resp_valid`=0 immediately; after release the sweep restarts and no stale response appears.
